// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types, sizes and helpers for the mux round-robin arbiter
package mux_arb_pkg;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) idx = SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set req bit after last, wrapping
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] last,
   output logic [SEL_W-1:0] win_idx,
   output logic             win_vld
);

   logic [SEL_W-1:0] idx;

   // Walk from the farthest offset down so the nearest requester overwrites.
   always_comb begin
      win_idx = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = last + SEL_W'(k);
         if (req[idx]) begin
            win_idx = idx;
            win_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin 4:1 mux arbiter with hold timeout
// Optional feature macro: ARB_LOCK_EN (lock input suppresses the hold timeout).
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             lock,
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] s,
   output logic             busy,
   output logic             timeout
);

   arb_state_t       state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0] s_q, s_d;
   logic [SEL_W-1:0] last_q, last_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             timeout_q, timeout_d;

   logic [N_REQ-1:0] pick_req;
   logic [SEL_W-1:0] pick_last;
   logic [SEL_W-1:0] win_idx;
   logic             win_vld;
   logic             lock_act;
   logic             owner_req;
   logic             others_pend;
   logic             hold_max;
   logic             rel_e;
   logic             revoke_e;

`ifdef ARB_LOCK_EN
   assign lock_act = lock;
`else
   logic unused_lock;
   assign unused_lock = lock;
   assign lock_act    = 1'b0;
`endif

   // While granted, the owner is masked out so one picker serves both handoff cases.
   assign pick_req  = (state_q == GRANT) ? (req & ~gnt_q) : req;
   assign pick_last = (state_q == GRANT) ? s_q : last_q;

   rr_pick u_rr_pick (
      .req     (pick_req),
      .last    (pick_last),
      .win_idx (win_idx),
      .win_vld (win_vld)
   );

   assign owner_req   = |(req & gnt_q);
   assign others_pend = |(req & ~gnt_q);
   assign hold_max    = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
   assign rel_e       = (state_q == GRANT) && !owner_req;
   assign revoke_e    = (state_q == GRANT) && owner_req && hold_max && others_pend && !lock_act;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         s_q        <= '0;
         last_q     <= SEL_W'(N_REQ - 1);
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         s_q        <= s_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (win_vld) state_d = GRANT;
         GRANT:   if (rel_e && !win_vld) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d      = gnt_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;
      if (state_q == IDLE) begin
         if (win_vld) begin
            gnt_d      = N_REQ'(1) << win_idx;
            hold_cnt_d = '0;
         end
      end else if (rel_e) begin
         last_d     = s_q;
         hold_cnt_d = '0;
         gnt_d      = win_vld ? (N_REQ'(1) << win_idx) : '0;
      end else if (revoke_e) begin
         timeout_d  = 1'b1;
         last_d     = s_q;
         hold_cnt_d = '0;
         gnt_d      = N_REQ'(1) << win_idx;
      end else if (!hold_max) begin
         hold_cnt_d = hold_cnt_q + CNT_W'(1);
      end
      s_d = (|gnt_d) ? onehot_to_idx(gnt_d) : s_q;
   end

   assign gnt     = gnt_q;
   assign s       = s_q;
   assign busy    = |gnt_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

   localparam int MAX_HOLD = 8;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic [3:0] req  = 4'b0000;
   logic       lock = 1'b0;
   logic [3:0] gnt;
   logic [1:0] s;
   logic       busy;
   logic       timeout;

   int n_checks = 0;
   int n_errors = 0;

   int m_owner   = -1;
   int m_last    = 3;
   int m_hold    = 0;
   int m_s       = 0;
   bit m_timeout = 1'b0;
   bit lock_en;

   mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .lock    (lock),
      .gnt     (gnt),
      .s       (s),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_next(input logic [3:0] mask, input int from);
      for (int k = 1; k <= 4; k++) begin
         if (mask[(from + k) % 4]) return (from + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_gnt();
      logic [3:0] one;
      one = 4'b0001;
      return (m_owner < 0) ? 4'b0000 : (one << m_owner);
   endfunction

   // Reference model: owner index, priority pointer and consecutive-hold count.
   always @(posedge clk or posedge rst) begin
      logic [3:0] own_mask;
      if (rst) begin
         m_owner = -1; m_last = 3; m_hold = 0; m_s = 0; m_timeout = 1'b0;
      end else begin
         m_timeout = 1'b0;
         if (m_owner < 0) begin
            m_owner = rr_next(req, m_last);
            m_hold  = 0;
         end else begin
            own_mask = exp_gnt();
            if (!req[m_owner]) begin
               m_last  = m_owner;
               m_owner = rr_next(req, m_last);
               m_hold  = 0;
            end else if (m_hold >= MAX_HOLD - 1 && (req & ~own_mask) != 4'b0000
                         && !(lock_en && lock)) begin
               m_timeout = 1'b1;
               m_last    = m_owner;
               m_owner   = rr_next(req & ~own_mask, m_last);
               m_hold    = 0;
            end else begin
               m_hold++;
            end
         end
         if (m_owner >= 0) m_s = m_owner;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("cmp_gnt", gnt, exp_gnt());
         check("cmp_s", s, m_s);
         check("cmp_busy", busy, m_owner >= 0);
         check("cmp_timeout", timeout, m_timeout);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req  = 4'b0000;
      lock = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] e;
`ifdef ARB_LOCK_EN
      lock_en = 1'b1;
`else
      lock_en = 1'b0;
`endif
      #2;
      check("rst_gnt", gnt, 4'b0000);
      check("rst_s", s, 2'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_timeout", timeout, 1'b0);
      tick();
      rst = 1'b0;

      // single requester grant and release
      req = 4'b0001;
      tick();
      check("t2_gnt", gnt, 4'b0001);
      check("t2_s", s, 2'd0);
      check("t2_busy", busy, 1'b1);
      req = 4'b0000;
      tick();
      check("t2_idle_gnt", gnt, 4'b0000);
      check("t2_idle_busy", busy, 1'b0);
      check("t2_idle_s", s, 2'd0);

      // asynchronous reset mid-grant
      do_reset();
      req = 4'b0100;
      tick();
      check("t1_pre_gnt", gnt, 4'b0100);
      check("t1_pre_s", s, 2'd2);
      #3;
      rst = 1'b1;
      #1;
      check("t1_async_gnt", gnt, 4'b0000);
      check("t1_async_busy", busy, 1'b0);
      check("t1_async_s", s, 2'd0);
      tick();
      req = 4'b0000;
      rst = 1'b0;

      // full rotation with pointer wrap 3 -> 0
      do_reset();
      req = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         e = 4'b0001 << (k % 4);
         check("t3_gnt_c1", gnt, e);
         tick();
         check("t3_gnt_c2", gnt, e);
         req[k % 4] = 1'b0;
         tick();
         req[k % 4] = 1'b1;
         check("t3_no_bubble", busy, 1'b1);
      end

      // hold timeout hands off after MAX_HOLD granted cycles
      do_reset();
      req = 4'b0011;
      for (int c = 1; c <= MAX_HOLD; c++) begin
         tick();
         check("t4_hold_gnt", gnt, 4'b0001);
         check("t4_no_to", timeout, 1'b0);
      end
      tick();
      check("t4_handoff_gnt", gnt, 4'b0010);
      check("t4_handoff_s", s, 2'd1);
      check("t4_pulse", timeout, 1'b1);
      tick();
      check("t4_pulse_end", timeout, 1'b0);
      check("t4_keep_gnt", gnt, 4'b0010);

      // lone requester never times out
      do_reset();
      req = 4'b0001;
      for (int c = 0; c < 20; c++) begin
         tick();
         check("t5_gnt", gnt, 4'b0001);
         check("t5_no_to", timeout, 1'b0);
      end

      // lock behaviour
      do_reset();
      req  = 4'b0011;
      lock = 1'b1;
`ifdef ARB_LOCK_EN
      for (int c = 0; c < 20; c++) begin
         tick();
         check("t6_lock_gnt", gnt, 4'b0001);
         check("t6_lock_no_to", timeout, 1'b0);
      end
      lock = 1'b0;
      tick();
      check("t6_unlock_gnt", gnt, 4'b0010);
`else
      for (int c = 1; c <= MAX_HOLD; c++) begin
         tick();
         check("t6_nolock_gnt", gnt, 4'b0001);
      end
      tick();
      check("t6_nolock_handoff", gnt, 4'b0010);
      check("t6_nolock_pulse", timeout, 1'b1);
`endif

      // release on the same edge as timeout counts as release
      do_reset();
      req = 4'b0011;
      for (int c = 1; c <= MAX_HOLD; c++) tick();
      check("t7_pre_gnt", gnt, 4'b0001);
      req = 4'b0010;
      tick();
      check("t7_gnt", gnt, 4'b0010);
      check("t7_no_to", timeout, 1'b0);

      req = 4'b0000;
      tick();
      tick();
      check("end_idle", busy, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
